// File: rtl/roachf_coarse_delay_if.sv
// Sample/config bundle for roachf_coarse_delay: master drives cfg and samples, slave is the delay.
interface roachf_coarse_delay_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DELAY_W = 10
);
  logic [31:0]        cfg_word;
  logic [DATA_W-1:0]  din;
  logic               sync_in;
  logic [DATA_W-1:0]  dout;
  logic               sync_out;
  logic [DELAY_W-1:0] delay_cur;
  logic               armed;
  logic [7:0]         load_count;

  modport master (
    output cfg_word, din, sync_in,
    input  dout, sync_out, delay_cur, armed, load_count
  );

  modport slave (
    input  cfg_word, din, sync_in,
    output dout, sync_out, delay_cur, armed, load_count
  );
endinterface

// File: rtl/roachf_coarse_delay.sv
// Integer-sample coarse delay: circular buffer with sync-aligned delay reloads, latency 2.
// Optional macro ROACHF_COARSE_DELAY_IMMEDIATE_EN: cfg_word[30] at arm time loads without sync.
module roachf_coarse_delay #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DELAY_W = 10
) (
  input logic                 user_clk,
  input logic                 user_rst,
  roachf_coarse_delay_if.slave bus
);
  localparam int unsigned Depth = 2 ** DELAY_W;

  typedef enum logic {StIdle, StArmed} state_e;

  state_e             state_q, state_d;
  logic               arm_q;
  logic               arm_pulse;
  logic               imm;
  logic [DELAY_W-1:0] cfg_val;
  logic [DELAY_W-1:0] pending_q, pending_d;
  logic [DELAY_W-1:0] delay_cur_q, delay_cur_d;
  logic [DELAY_W-1:0] delay_eff;
  logic [7:0]         load_count_q, load_count_d;
  logic [DELAY_W-1:0] wr_ptr_q;
  logic [DELAY_W-1:0] rd_addr;
  logic [DELAY_W:0]   fill_q;
  logic [DATA_W-1:0]  mem [Depth];
  logic [DATA_W-1:0]  rd_q, dout_q;
  logic [1:0]         sync_q;
  logic               unused_cfg;

  assign cfg_val   = bus.cfg_word[DELAY_W-1:0];
  assign arm_pulse = bus.cfg_word[31] & ~arm_q;

`ifdef ROACHF_COARSE_DELAY_IMMEDIATE_EN
  assign imm        = bus.cfg_word[30];
  assign unused_cfg = ^bus.cfg_word[29:DELAY_W];
`else
  assign imm        = 1'b0;
  assign unused_cfg = ^bus.cfg_word[30:DELAY_W];
`endif

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    delay_cur_d  = delay_cur_q;
    load_count_d = load_count_q;
    delay_eff    = delay_cur_q;
    case (state_q)
      StIdle: begin
        if (arm_pulse) begin
          if (imm) begin
            delay_cur_d  = cfg_val;
            load_count_d = load_count_q + 8'd1;
          end else begin
            pending_d = cfg_val;
            state_d   = StArmed;
          end
        end
      end
      StArmed: begin
        // The sync cycle itself already reads with the new delay.
        if (bus.sync_in) begin
          delay_eff    = pending_q;
          delay_cur_d  = pending_q;
          load_count_d = load_count_q + 8'd1;
          state_d      = StIdle;
        end
        if (arm_pulse) begin
          pending_d = cfg_val;
          state_d   = StArmed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q      <= StIdle;
      arm_q        <= 1'b0;
      pending_q    <= '0;
      delay_cur_q  <= '0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      arm_q        <= bus.cfg_word[31];
      pending_q    <= pending_d;
      delay_cur_q  <= delay_cur_d;
      load_count_q <= load_count_d;
    end
  end

  assign rd_addr = wr_ptr_q - delay_eff;

  always_ff @(posedge user_clk) begin
    mem[wr_ptr_q] <= bus.din;
  end

  // Zero delay bypasses the RAM; slots older than the fill count were never written.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      rd_q     <= '0;
      dout_q   <= '0;
      sync_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (!fill_q[DELAY_W]) fill_q <= fill_q + 1'b1;
      if (delay_eff == '0)                  rd_q <= bus.din;
      else if ({1'b0, delay_eff} > fill_q)  rd_q <= '0;
      else                                  rd_q <= mem[rd_addr];
      dout_q <= rd_q;
      sync_q <= {sync_q[0], bus.sync_in};
    end
  end

  assign bus.dout       = dout_q;
  assign bus.sync_out   = sync_q[1];
  assign bus.delay_cur  = delay_cur_q;
  assign bus.armed      = (state_q == StArmed);
  assign bus.load_count = load_count_q;
endmodule

// File: tb/tb_roachf_coarse_delay.sv
// Bench for roachf_coarse_delay: sample-history reference model plus directed literal checks.
module tb_roachf_coarse_delay;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   scyc     = 0;

  roachf_coarse_delay_if #(.DATA_W(32), .DELAY_W(10)) bus ();

  roachf_coarse_delay #(.DATA_W(32), .DELAY_W(10)) dut (
    .user_clk (clk),
    .user_rst (rst),
    .bus      (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got 0x%08h, expected 0x%08h", nm, $time, got, exp);
    end
  endtask

  // Reference model: delay history per absolute cycle since reset.
  logic [31:0] hist [int];
  int          m_cyc;
  int          m_cur, m_pend, m_cnt;
  bit          m_armed, m_arm_prev;
  logic [31:0] e_dout [2];
  bit          e_sync [2];

  always @(negedge clk) begin
    if (rst) begin
      hist.delete();
      m_cyc = 0; m_cur = 0; m_pend = 0; m_cnt = 0;
      m_armed = 0; m_arm_prev = 0;
      e_dout[0] = '0; e_dout[1] = '0;
      e_sync[0] = 0;  e_sync[1] = 0;
    end else begin
      logic [31:0] cfg, din, v;
      bit          sy, pulse, imm;
      int          d;
      chk("dout",       bus.dout,                e_dout[0]);
      chk("sync_out",   {31'd0, bus.sync_out},   {31'd0, e_sync[0]});
      chk("delay_cur",  {22'd0, bus.delay_cur},  m_cur);
      chk("armed",      {31'd0, bus.armed},      {31'd0, m_armed});
      chk("load_count", {24'd0, bus.load_count}, m_cnt % 256);

      cfg = bus.cfg_word; din = bus.din; sy = bus.sync_in;
      pulse = cfg[31] && !m_arm_prev;
`ifdef ROACHF_COARSE_DELAY_IMMEDIATE_EN
      imm = cfg[30];
`else
      imm = 1'b0;
`endif
      d = (m_armed && sy) ? m_pend : m_cur;
      if (d == 0)          v = din;
      else if (d > m_cyc)  v = '0;
      else                 v = hist[m_cyc - d];
      hist[m_cyc] = din;
      e_dout[0] = e_dout[1]; e_dout[1] = v;
      e_sync[0] = e_sync[1]; e_sync[1] = sy;

      if (m_armed) begin
        if (sy) begin m_cur = m_pend; m_cnt++; m_armed = 0; end
        if (pulse) begin m_pend = int'(cfg[9:0]); m_armed = 1; end
      end else if (pulse) begin
        if (imm) begin m_cur = int'(cfg[9:0]); m_cnt++; end
        else begin m_pend = int'(cfg[9:0]); m_armed = 1; end
      end
      m_arm_prev = cfg[31];
      m_cyc++;
    end
  end

  task automatic drive(input logic [31:0] cfg, input logic sy, input logic [31:0] d);
    bus.cfg_word = cfg;
    bus.sync_in  = sy;
    bus.din      = d;
    @(posedge clk);
    #2;
    scyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cfg_word = '0; bus.sync_in = 1'b0; bus.din = '0;
    repeat (3) @(posedge clk);
    #2;
    rst  = 1'b0;
    scyc = 0;
  endtask

  initial begin
    logic [31:0] cfg_v;
    bus.cfg_word = '0; bus.sync_in = 1'b0; bus.din = '0;
    do_reset();
    #1;
    chk("rst_dout",  bus.dout, 32'd0);
    chk("rst_armed", {31'd0, bus.armed}, 32'd0);
    chk("rst_count", {24'd0, bus.load_count}, 32'd0);
    #0;

    // Directed: passthrough, sync-aligned load, overwrite, simultaneous arm+sync.
    cfg_v = '0;
    for (int k = 0; k < 300; k++) begin
      case (k)
        100: cfg_v = 32'h8000_0005;
        170: cfg_v = 32'h8000_0003;
        180: cfg_v = 32'h8000_0007;
        220: cfg_v = 32'h8000_0009;
        260: cfg_v = 32'h8000_000B;
        280: cfg_v = 32'h8000_0002;
        120, 171, 190, 230, 270, 285: cfg_v = '0;
        default: ;
      endcase
      drive(cfg_v, (k inside {5, 150, 200, 220, 240, 280, 290}), k);
      case (scyc)
        7:   chk("t1_sync_out", {31'd0, bus.sync_out}, 32'd1);
        12:  chk("t1_dout", bus.dout, 32'd10);
        101: chk("t2_armed_101", {31'd0, bus.armed}, 32'd1);
        150: chk("t2_armed_150", {31'd0, bus.armed}, 32'd1);
        151: begin
          chk("t2_delay", {22'd0, bus.delay_cur}, 32'd5);
          chk("t2_count", {24'd0, bus.load_count}, 32'd1);
          chk("t2_armed_151", {31'd0, bus.armed}, 32'd0);
        end
        152: begin
          chk("t2_dout", bus.dout, 32'd145);
          chk("t2_sync_out", {31'd0, bus.sync_out}, 32'd1);
        end
        201: begin
          chk("t3_delay", {22'd0, bus.delay_cur}, 32'd7);
          chk("t3_count", {24'd0, bus.load_count}, 32'd2);
        end
        202: chk("t3_dout", bus.dout, 32'd193);
        221: begin
          chk("t4_delay_hold", {22'd0, bus.delay_cur}, 32'd7);
          chk("t4_armed", {31'd0, bus.armed}, 32'd1);
        end
        241: chk("t4_delay", {22'd0, bus.delay_cur}, 32'd9);
        242: chk("t4_dout", bus.dout, 32'd231);
        281: begin
          chk("t4b_delay", {22'd0, bus.delay_cur}, 32'd11);
          chk("t4b_armed", {31'd0, bus.armed}, 32'd1);
        end
        291: begin
          chk("t4b_delay2", {22'd0, bus.delay_cur}, 32'd2);
          chk("t4b_count", {24'd0, bus.load_count}, 32'd5);
        end
        default: ;
      endcase
    end

    // Max delay after reset over stale RAM, then 0 -> 1023 -> 0 across pointer wraps.
    do_reset();
    for (int k = 0; k < 2200; k++) begin
      case (k)
        2:    cfg_v = 32'h8000_03FF;
        1100: cfg_v = 32'h8000_0000;
        1300: cfg_v = 32'h8000_03FF;
        1500: cfg_v = 32'h8000_0000;
        3, 1101, 1301, 1501: cfg_v = '0;
        default: ;
      endcase
      drive(cfg_v, (k inside {10, 1110, 1310, 1510}), 32'h1000 + k);
      case (scyc)
        11:   chk("t5_delay", {22'd0, bus.delay_cur}, 32'd1023);
        12:   chk("t5_guard", bus.dout, 32'd0);
        1024: chk("t5_guard_last", bus.dout, 32'd0);
        1025: chk("t5_first", bus.dout, 32'h1000);
        default: ;
      endcase
    end

    // Immediate-load bit: loads at once with the macro, waits for sync without it.
    do_reset();
    for (int k = 0; k < 64; k++) begin
      cfg_v = (k >= 50 && k < 55) ? 32'hC000_0004 : '0;
      drive(cfg_v, (k == 58), k);
`ifdef ROACHF_COARSE_DELAY_IMMEDIATE_EN
      if (scyc == 51) begin
        chk("t6_delay", {22'd0, bus.delay_cur}, 32'd4);
        chk("t6_armed", {31'd0, bus.armed}, 32'd0);
        chk("t6_count", {24'd0, bus.load_count}, 32'd1);
      end
      if (scyc == 53) chk("t6_dout", bus.dout, 32'd47);
`else
      if (scyc == 51) begin
        chk("t6_delay", {22'd0, bus.delay_cur}, 32'd0);
        chk("t6_armed", {31'd0, bus.armed}, 32'd1);
      end
      if (scyc == 59) chk("t6_delay_sync", {22'd0, bus.delay_cur}, 32'd4);
`endif
    end

    // Random traffic with a mid-run reset.
    cfg_v = '0;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      if ($urandom_range(0, 14) == 0) begin
        cfg_v[31]    = ~cfg_v[31];
        cfg_v[30]    = ($urandom_range(0, 3) == 0);
        cfg_v[29:10] = 20'($urandom());
        cfg_v[9:0]   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                   : 10'($urandom_range(0, 40));
      end
      drive(cfg_v, ($urandom_range(0, 19) == 0), $urandom());
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/roachf_coarse_delay.md
Name: roachf_coarse_delay

Overview:
- Integer-sample coarse delay stage in the user_clk domain. It sits directly downstream of the software delay register and consumes its 32-bit user_data_out word.
- Software writes a delay value and toggles an arm bit. The block latches the value and applies it at the next sync pulse.
- Data is delayed through a circular buffer. Sync passes through with fixed pipeline latency only.

Parameters:
- DATA_W, 32, width of the sample word.
- DELAY_W, 10, delay field width; buffer depth 2^DELAY_W; max delay 2^DELAY_W-1.

Ports:
- user_clk  in  1  single clock for all logic.
- user_rst  in  1  asynchronous, active-high reset.
- cfg_word  in  32  delay register output; [DELAY_W-1:0] = delay value, [31] = arm, [30] = immediate (macro only).
- din  in  DATA_W  input sample, one per cycle, continuous.
- sync_in  in  1  frame sync pulse, one cycle wide.
- dout  out  DATA_W  delayed sample.
- sync_out  out  1  sync_in delayed 2 cycles.
- delay_cur  out  DELAY_W  delay currently in effect.
- armed  out  1  high while a load is pending.
- load_count  out  8  number of applied loads; wraps 255->0.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - dout=0, sync_out=0, delay_cur=0, armed=0, load_count=0, state IDLE, wr_ptr=0, fill=0, arm history=0.
  - Buffer RAM contents are not cleared.
- Arm detect: cfg_word[31] is registered to arm_q. arm_pulse = cfg_word[31] & ~arm_q. Holding [31] high does not re-arm.
- FSM:
  - IDLE: on arm_pulse, pending <= cfg_word[DELAY_W-1:0]; go to ARMED.
  - ARMED: on sync_in, delay_cur <= pending, load_count++, go to IDLE.
  - ARMED: on arm_pulse without sync_in, pending is overwritten and the state stays ARMED.
- armed = (state==ARMED), registered.
- Simultaneous arm_pulse and sync_in:
  - From IDLE: arm only. The load applies at the next sync, not this one.
  - From ARMED: the old pending value is applied at this sync. The new value becomes pending and the state stays ARMED.
- Effective delay D_n for the cycle n read: D_n = pending if (state==ARMED && sync_in), else delay_cur. The new delay therefore takes effect on the sync cycle itself.
- Datapath:
  - Every cycle, write din at wr_ptr, then wr_ptr++ (mod 2^DELAY_W).
  - Read address = wr_ptr - D_n (mod 2^DELAY_W).
  - Output rule: dout(n+2) = din(n - D_n). Read is registered, plus an output register, giving fixed latency 2.
  - D_n=0: bypass path; dout(n+2) = din(n). No read-during-write dependency on the RAM.
  - sync_out(n+2) = sync_in(n). The sample output with sync_out is din(sync cycle - D_new).
- Fill guard:
  - fill counts cycles since reset and saturates at 2^DELAY_W.
  - If D_n > fill_n (slot never written), the dout for that read is 0.
- No internal limit on delay. Every DELAY_W-bit value is legal, including max 2^DELAY_W-1.
- Delay decrease/increase at sync: output samples are repeated or skipped accordingly. This is intended; there is no smoothing.
- Reset mid-operation: pending load is discarded. delay_cur returns to 0. Output is zero until fresh data is written.

Optional Feature:
- Macro: ROACHF_COARSE_DELAY_IMMEDIATE_EN.
- Defined: if cfg_word[30]=1 at the arm_pulse cycle, the load bypasses ARMED:
  - delay_cur <= value on the next edge; load_count++; state stays IDLE; armed stays 0.
  - D_n for the following cycle uses the new value.
- Not defined: cfg_word[30] is ignored. All loads wait for sync.

Test Plan:
1. Reset, then run 20 cycles with din=cycle index. Expect delay_cur=0, armed=0, and dout(n+2)=n. Expect sync_out equal to sync_in delayed 2 cycles.
2. Write cfg_word=0x80000005 at cycle 100 and pulse sync_in at 150. Expect armed=1 over cycles 101-150 and load_count=1. Expect dout at cycle 152 = din(145), with sync_out=1 at 152. delay_cur=5 from cycle 151.
3. Write 0x80000003, drop [31], then write 0x80000007 before sync. On sync at cycle s, expect delay_cur=7, dout(s+2)=din(s-7), and load_count incremented by 1.
4. Raise arm and sync_in in the same cycle from IDLE. Expect no change in delay_cur and armed=1. The load applies at the next sync.
5. After reset, load delay 1023 at the first sync (cycle 10). Expect dout=0 until the fill guard clears, then dout(n+2)=din(n-1023). Also cover a second case: load 0, then 1023, then 0, checking wr_ptr wrap after 1024 cycles.
6. Macro defined: write 0xC0000004 at cycle 50 with no sync. Expect delay_cur=4 at 51, armed=0, load_count=1, and dout(53)=din(47). Macro undefined: the same write arms and waits for sync.
